// File: rtl/or1k_pcu_v2.sv
// or1k_pcu_v2: SPR group-7 performance counter unit with hi/lo shadows and sticky overflow.
// Define OR1K_PCU_OVF_IRQ_EN to enable OVIE bits and the overflow interrupt.
module or1k_pcu_v2 #(
  parameter int NUM_COUNTERS = 8,
  parameter int NUM_EVENTS   = 11,
  parameter int CNT_WIDTH    = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spr_access_i,
  input  logic                  spr_we_i,
  input  logic                  spr_re_i,
  input  logic [15:0]           spr_addr_i,
  input  logic [31:0]           spr_dat_i,
  output logic                  spr_bus_ack_o,
  output logic [31:0]           spr_dat_o,
  input  logic                  spr_sys_mode_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  freeze_i,
  output logic                  pcu_irq_o
);
  localparam int IW = $clog2(NUM_EVENTS + 1);
  localparam int HW = (CNT_WIDTH > 32) ? CNT_WIDTH - 32 : 1;
  localparam logic [31:0] EV_M = 32'(((64'd1 << NUM_EVENTS) - 64'd1) << 3);
`ifdef OR1K_PCU_OVF_IRQ_EN
  localparam logic [31:0] PCMR_WM = 32'h8000_0006 | EV_M;
`else
  localparam logic [31:0] PCMR_WM = 32'h0000_0006 | EV_M;
`endif

  logic                    r_ack;
  logic [31:0]             r_dat;
  logic [CNT_WIDTH-1:0]    r_cnt [NUM_COUNTERS];
  logic [31:0]             r_pcmr [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] r_ovf;
  logic [HW-1:0]           r_rd_sh, r_wr_sh;

  logic                    w_go, w_hit, w_wr, w_rd, w_impl;
  logic [1:0]              w_cls;
  logic [2:0]              w_idx;
  logic [CNT_WIDTH-1:0]    w_sel_cnt;
  logic [31:0]             w_sel_pcmr, w_rdata;
  logic [63:0]             w_cur64, w_full;
  logic [IW-1:0]           w_inc [NUM_COUNTERS];
  logic [CNT_WIDTH:0]      w_sum [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] w_en, w_cw, w_carry, w_w1c;
  logic                    w_unused;

  assign w_go    = spr_access_i & ~r_ack;
  assign w_hit   = spr_addr_i[15:11] == 5'd7;
  assign w_cls   = spr_addr_i[4:3];
  assign w_idx   = spr_addr_i[2:0];
  assign w_wr    = w_go & spr_we_i & spr_sys_mode_i & w_hit;
  assign w_rd    = w_go & spr_re_i;
  assign w_cur64 = 64'(w_sel_cnt);
  assign w_full  = {32'(r_wr_sh), spr_dat_i};
  assign w_w1c   = (w_wr && w_cls == 2'd3 && w_idx == 3'd0) ? spr_dat_i[NUM_COUNTERS-1:0] : '0;
  assign w_unused = ^{spr_addr_i[10:5], w_cur64};

  always_comb begin
    w_sel_cnt  = '0;
    w_sel_pcmr = '0;
    w_impl     = 1'b0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (w_idx == 3'(i)) begin
        w_sel_cnt  = r_cnt[i];
        w_sel_pcmr = r_pcmr[i] | 32'h1;
        w_impl     = 1'b1;
      end
    end
  end

  // High-half reads return the shadow latched by the last low-half read.
  always_comb begin
    w_rdata = (!w_hit || (!w_impl && w_cls != 2'd3)) ? 32'h0 :
              (w_cls == 2'd0) ? w_cur64[31:0] :
              (w_cls == 2'd1) ? (spr_sys_mode_i ? w_sel_pcmr : 32'h0) :
              (w_cls == 2'd2) ? ((CNT_WIDTH > 32) ? 32'(r_rd_sh) : 32'h0) :
              ((spr_sys_mode_i && w_idx == 3'd0) ? 32'(r_ovf) : 32'h0);
  end

  always_comb begin
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      w_inc[i] = '0;
      for (int j = 0; j < NUM_EVENTS; j++)
        w_inc[i] = w_inc[i] + IW'(event_i[j] & r_pcmr[i][3+j]);
      w_en[i]    = ~freeze_i & ((r_pcmr[i][1] & spr_sys_mode_i) | (r_pcmr[i][2] & ~spr_sys_mode_i));
      w_cw[i]    = w_wr && w_cls == 2'd0 && w_idx == 3'(i);
      w_sum[i]   = {1'b0, r_cnt[i]} + (CNT_WIDTH+1)'(w_inc[i]);
      w_carry[i] = w_en[i] & ~w_cw[i] & w_sum[i][CNT_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_dat   <= '0;
      r_ovf   <= '0;
      r_rd_sh <= '0;
      r_wr_sh <= '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        r_cnt[i]  <= '0;
        r_pcmr[i] <= '0;
      end
    end else begin
      r_ack <= spr_access_i & ~r_ack;
      r_dat <= w_rd ? w_rdata : 32'h0;
      r_ovf <= (r_ovf & ~w_w1c) | w_carry;
      if (w_rd && w_hit && w_impl && w_cls == 2'd0)
        r_rd_sh <= w_cur64[32 +: HW];
      if (CNT_WIDTH > 32 && w_wr && w_impl && w_cls == 2'd2)
        r_wr_sh <= spr_dat_i[HW-1:0];
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        r_cnt[i] <= w_cw[i] ? w_full[CNT_WIDTH-1:0] : w_en[i] ? w_sum[i][CNT_WIDTH-1:0] : r_cnt[i];
        if (w_wr && w_cls == 2'd1 && w_idx == 3'(i))
          r_pcmr[i] <= spr_dat_i & PCMR_WM;
      end
    end
  end

  assign spr_bus_ack_o = r_ack;
  assign spr_dat_o     = r_dat;

`ifdef OR1K_PCU_OVF_IRQ_EN
  logic [NUM_COUNTERS-1:0] w_ovie;
  always_comb
    for (int i = 0; i < NUM_COUNTERS; i++) w_ovie[i] = r_pcmr[i][31];
  assign pcu_irq_o = |(r_ovf & w_ovie);
`else
  assign pcu_irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_or1k_pcu_v2.sv
// tb_or1k_pcu_v2: directed self-checking bench for or1k_pcu_v2 (default parameters).
module tb_or1k_pcu_v2;
  logic        clk = 1'b0;
  logic        rst, acc, we, re, sys, frz;
  logic [15:0] addr;
  logic [31:0] wdat;
  logic [10:0] ev;
  logic        ack, irq;
  logic [31:0] dat_o;
  int          checks = 0, failures = 0;

`ifdef OR1K_PCU_OVF_IRQ_EN
  localparam logic [31:0] EXP_PCMR3 = 32'h8000_000B;
  localparam logic        EXP_IRQ   = 1'b1;
`else
  localparam logic [31:0] EXP_PCMR3 = 32'h0000_000B;
  localparam logic        EXP_IRQ   = 1'b0;
`endif
  localparam logic [15:0] PCCR = 16'h3800, PCMR = 16'h3808, PCHI = 16'h3810, PCSR = 16'h3818;

  always #5 clk = ~clk;

  or1k_pcu_v2 dut (
    .clk(clk), .rst(rst),
    .spr_access_i(acc), .spr_we_i(we), .spr_re_i(re),
    .spr_addr_i(addr), .spr_dat_i(wdat),
    .spr_bus_ack_o(ack), .spr_dat_o(dat_o),
    .spr_sys_mode_i(sys), .event_i(ev), .freeze_i(frz),
    .pcu_irq_o(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [10:0] e = '0);
    @(negedge clk);
    acc = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdat = d; ev = e;
    @(negedge clk);
    acc = 1'b0; we = 1'b0; ev = '0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d, output logic a_seen);
    @(negedge clk);
    acc = 1'b1; we = 1'b0; re = 1'b1; addr = a;
    @(posedge clk);
    #1;
    d = dat_o;
    a_seen = ack;
    @(negedge clk);
    acc = 1'b0; re = 1'b0;
  endtask

  task automatic rdc(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        k;
    rd(a, d, k);
    chk(tag, d, exp);
  endtask

  task automatic pulse(input logic [10:0] e, input int n);
    @(negedge clk);
    ev = e;
    repeat (n) @(negedge clk);
    ev = '0;
  endtask

  initial begin
    logic [31:0] d;
    logic        k;
    rst = 1'b1; acc = 1'b0; we = 1'b0; re = 1'b0; sys = 1'b1; frz = 1'b0;
    addr = '0; wdat = '0; ev = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    for (int i = 0; i < 8; i++) rdc($sformatf("rst_pcmr%0d", i), PCMR + 16'(i), 32'h1);
    rd(PCCR, d, k);
    chk("rst_pccr0", d, 32'h0);
    chk("read_ack", 32'(k), 32'h1);
    @(posedge clk);
    #1;
    chk("ack_drop", 32'(ack), 32'h0);
    chk("dat_idle", dat_o, 32'h0);

    wr(PCMR, 32'h0000_003A);
    rdc("pcmr0_rb", PCMR, 32'h0000_003B);
    pulse(11'h7, 10);
    rdc("multi_cnt", PCCR, 32'd30);
    rdc("multi_hi", PCHI, 32'h0);
    frz = 1'b1;
    pulse(11'h7, 3);
    frz = 1'b0;
    rdc("freeze", PCCR, 32'd30);

    wr(PCMR + 16'd2, 32'h0000_000C);
    pulse(11'h1, 5);
    rdc("cium_sys", PCCR + 16'd2, 32'h0);
    @(negedge clk);
    sys = 1'b0;
    ev = 11'h1;
    repeat (4) @(negedge clk);
    ev = '0;
    rdc("cium_user", PCCR + 16'd2, 32'd4);
    wr(PCCR + 16'd2, 32'd100);
    rdc("user_wr", PCCR + 16'd2, 32'd4);
    rdc("user_pcmr", PCMR + 16'd2, 32'h0);
    rdc("user_pcsr", PCSR, 32'h0);
    sys = 1'b1;

    wr(PCMR + 16'd3, 32'h8000_000A);
    rdc("pcmr3_rb", PCMR + 16'd3, EXP_PCMR3);
    wr(PCHI + 16'd3, 32'h0000_FFFF);
    wr(PCCR + 16'd3, 32'hFFFF_FFFF);
    rdc("pre_ovf_lo", PCCR + 16'd3, 32'hFFFF_FFFF);
    rdc("pre_ovf_hi", PCHI + 16'd3, 32'h0000_FFFF);
    pulse(11'h1, 1);
    chk("ovf_irq", 32'(irq), 32'(EXP_IRQ));
    rdc("wrap_lo", PCCR + 16'd3, 32'h0);
    rdc("wrap_hi", PCHI + 16'd3, 32'h0);
    rdc("pcsr_set", PCSR, 32'h8);
    wr(PCSR, 32'h8);
    chk("irq_clr", 32'(irq), 32'h0);
    rdc("pcsr_clr", PCSR, 32'h0);

    wr(PCHI + 16'd3, 32'h0000_FFFF);
    wr(PCCR + 16'd3, 32'hFFFF_FFFF);
    pulse(11'h1, 1);
    wr(PCHI + 16'd3, 32'h0000_FFFF);
    wr(PCCR + 16'd3, 32'hFFFF_FFFF);
    wr(PCSR, 32'h8, 11'h1);
    rdc("w1c_vs_set", PCSR, 32'h8);
    wr(PCSR, 32'h8);
    rdc("pcsr_clr2", PCSR, 32'h0);

    wr(PCHI + 16'd3, 32'h0);
    wr(PCCR + 16'd3, 32'hFFFF_FFFF);
    rdc("sh_lo1", PCCR + 16'd3, 32'hFFFF_FFFF);
    pulse(11'h1, 1);
    rdc("sh_hi_latched", PCHI + 16'd3, 32'h0);
    rdc("sh_lo2", PCCR + 16'd3, 32'h0);
    rdc("sh_hi2", PCHI + 16'd3, 32'h1);

    wr(PCMR + 16'd1, 32'h0000_000A);
    wr(PCCR + 16'd1, 32'd5, 11'h1);
    rdc("collision", PCCR + 16'd1, 32'd5);

    rdc("out_of_group", 16'h3000, 32'h0);
    rdc("pcsr_bad_off", PCSR + 16'd1, 32'h0);

    @(negedge clk);
    acc = 1'b1; we = 1'b1; addr = PCMR + 16'd4; wdat = 32'h0000_003A; rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_ack", 32'(ack), 32'h0);
    @(negedge clk);
    acc = 1'b0; we = 1'b0; rst = 1'b0;
    rdc("rst_mid_pcmr4", PCMR + 16'd4, 32'h1);
    rdc("rst_mid_pccr0", PCCR, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/or1k_pcu_v2.md
# or1k_pcu_v2

Second-generation performance counter unit for the OR1K core, on the SPR bus in group 7 (performance counters).
- Provides up to 8 counters with a configurable counter width and event count.
- Counters wider than 32 bits are read and written through a consistent hi/lo shadow.
- Overflow is recorded in sticky flags and can raise an interrupt.
- The SPR handshake is registered.

## Interface
Parameters:
- NUM_COUNTERS, 8, number of counters implemented (1..8); unimplemented indices read 0 and ignore writes.
- NUM_EVENTS, 11, width of event vector (1..16).
- CNT_WIDTH, 48, counter width in bits (32..64).

Ports (clock and reset: clock clk; reset rst, synchronous, active-high):
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- spr_access_i  in  1  SPR access request for this unit; held until ack.
- spr_we_i  in  1  write strobe, qualified by spr_access_i.
- spr_re_i  in  1  read strobe, qualified by spr_access_i.
- spr_addr_i  in  16  SPR address.
- spr_dat_i  in  32  write data.
- spr_bus_ack_o  out  1  one-cycle access acknowledge.
- spr_dat_o  out  32  registered read data, valid while ack is high.
- spr_sys_mode_i  in  1  1 = supervisor, 0 = user.
- event_i  in  NUM_EVENTS  per-cycle event pulses.
- freeze_i  in  1  debug halt; stops all counting.
- pcu_irq_o  out  1  overflow interrupt.

## Operation
Address decode:
- Hit requires spr_addr_i[15:11]==7.
- Register class is spr_addr_i[4:3]:
  - 0: PCCRn low 32 bits.
  - 1: PCMRn.
  - 2: PCCRn high bits [CNT_WIDTH-1:32], zero-extended to 32 bits.
  - 3: PCSR, offset 24 only; other class-3 offsets read 0.
- Index n = spr_addr_i[2:0].
- Any access outside group 7 is still acked and reads 0.

PCMRn layout:
- bit0 CP: read-only 1.
- bit1 CISM: count in supervisor mode.
- bit2 CIUM: count in user mode.
- bits[3+NUM_EVENTS-1:3]: event mask.
- bit31 OVIE: overflow interrupt enable.
- All other bits read 0.

PCSR:
- bit i = sticky overflow flag of counter i.
- Writing 1 to a bit clears it (write-1-to-clear).

Access rights:
- Writes take effect only when spr_sys_mode_i=1; user-mode writes are acked and discarded.
- In user mode, PCMR and PCSR read 0; PCCR is readable in both modes.

Counting, each cycle for counter i:
- Enabled when `!freeze_i && ((CISM && sys) || (CIUM && !sys))`.
- inc_i = popcount(event_i & mask_i). Its width is clog2(NUM_EVENTS+1).
- When enabled: cnt_i <= cnt_i + inc_i, modulo 2^CNT_WIDTH.
- A carry out of bit CNT_WIDTH-1 sets ovf[i].

Shadow registers (one of each per unit):
- Read of PCCRn low: returns cnt[31:0] and latches cnt[CNT_WIDTH-1:32] into rd_shadow.
- Read of PCCRn high: returns rd_shadow, not the live value.
- Write of PCCRn high: loads wr_shadow.
- Write of PCCRn low: commits cnt_n <= {wr_shadow, spr_dat_i} in one cycle.
- Software sequence: read low then high; write high then low.
- CNT_WIDTH=32: high-class accesses read 0 and ignore writes; shadows are not implemented.

Simultaneous events:
- SPR write to PCCRn in the same cycle as counting: the write wins and that cycle's increment is dropped.
- PCSR W1C in the same cycle as a new overflow of the same bit: the set wins.

## Timing
- Access sampled at edge N produces spr_bus_ack_o=1 and valid spr_dat_o for the cycle after edge N. Register effect is visible from edge N.
- Ack logic: ack_q <= spr_access_i & ~ack_q. The master must drop spr_access_i the cycle after it sees ack. If access is held, ack re-fires every other cycle.
- spr_dat_o is 0 whenever ack is low.
- Counter update latency: event at edge N is visible in the counter after edge N.
- An overflow at edge N sets ovf after N. pcu_irq_o is derived combinationally from the flags and rises in the same cycle.
- Reset values:
  - counters: 0.
  - PCMR: 0x1 (CP only).
  - PCSR: 0.
  - shadows: 0.
  - spr_bus_ack_o: 0.
  - spr_dat_o: 0.
  - pcu_irq_o: 0.
- rst asserted mid-access: the pending ack is cancelled and no write is committed.

## Configuration
- OR1K_PCU_OVF_IRQ_EN defined: pcu_irq_o = |(ovf & OVIE[i]) over implemented counters.
- Not defined:
  - pcu_irq_o is tied 0.
  - OVIE bits read 0 and ignore writes.
  - Overflow flags and PCSR still operate.

## Test plan
- Reset readback: after reset, read PCMR0..7 in supervisor mode -> 0x1; read PCCR0 -> 0; pcu_irq_o=0.
- Multi-event count: PCMR0 = CISM | mask bits 3,4,5; sys=1; drive three events together for 10 cycles -> PCCR0 low reads 30.
- User vs supervisor:
  - CIUM only, sys=1 with events -> no count.
  - Same with sys=0 -> counts.
  - User write to PCCR0 -> ignored; user read of PCMR0 -> 0.
- 48-bit overflow (macro on): write high 0xFFFF then low 0xFFFFFFFF; OVIE=1; one event -> counter wraps to 0, PCSR=0x1, pcu_irq_o=1; W1C 0x1 -> irq drops the next cycle.
- Shadow consistency: with the counter at 0x0000_FFFF_FFFF, read low, then 1 event, then read high -> high returns 0 (latched value), and a fresh low/high read sequence returns 0x0001_0000_0000.
- Collision: write PCCR1 = 5 in a cycle with an enabled event -> PCCR1 reads 5, not 6.
